div_cdb_buffer: RTL and testbench
=================================

Name: div_cdb_buffer

Overview:
Writeback buffer directly downstream of the 32-stage pipelined divider. It captures each completed divide/remainder result (value, physical destination tag, PC) and presents it to the common data bus (CDB) arbiter with a req/grant handshake. The divider pipeline cannot stall, so the block also issues credits to the divider's issue stage. These credits guarantee that every in-flight operation has a free buffer slot when it completes.

Parameters:
DEPTH, 8, number of buffer entries (power of 2, >=2)
DATA_W, 32, result width
TAG_W, 7, physical register tag width
PC_W, 32, PC width
MAX_INFLIGHT, 33, maximum operations in the divider pipeline (sizes the in-flight counter)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
issue_fire  input  1  an operation entered the divider this cycle (divider start)
issue_ok  output  1  credit available; upstream may assert issue_fire only when high
in_valid  input  1  divider done pulse; result fields valid this cycle
in_result  input  DATA_W  divider Result
in_tag  input  TAG_W  divider Physical_address_out
in_pc  input  PC_W  divider PC_out
cdb_req  output  1  head entry valid, requesting CDB
cdb_grant  input  1  arbiter grants CDB to this unit this cycle
cdb_result  output  DATA_W  head result
cdb_tag  output  TAG_W  head destination tag
cdb_pc  output  PC_W  head PC
count  output  $clog2(DEPTH)+1  entries currently held
overflow_err  output  1  sticky: push attempted while full

Behaviour:
- Reset is asynchronous and active-high, on clock clk. It clears the read/write pointers, count, in-flight counter and overflow_err. Outputs after reset: cdb_req=0, cdb_result/tag/pc=0, count=0, issue_ok=1 (DEPTH>0).
- Storage is a circular FIFO of DEPTH entries {result, tag, pc}, with pointers of width $clog2(DEPTH) that wrap modulo DEPTH.
- Push: in_valid=1 writes the entry at wr_ptr and advances wr_ptr.
- Pop: cdb_req & cdb_grant advances rd_ptr. cdb_grant while cdb_req=0 is ignored.
- Simultaneous push and pop: both take effect and count is unchanged. When full, the pop frees the slot, so the push is legal and is not an overflow.
- Head outputs: cdb_req = (count!=0). cdb_result/tag/pc are taken from the entry at rd_ptr when count!=0, and are 0 when empty.
- Latency without bypass: in_valid at edge N means cdb_req=1 with that data after edge N (visible in cycle N+1), provided the buffer was empty. Results leave in completion order; no reordering.
- In-flight counter: +1 on issue_fire, -1 on in_valid, unchanged when both occur in the same cycle. Width holds MAX_INFLIGHT. It saturates at 0 and never underflows on a spurious in_valid.
- Credit: issue_ok = (inflight + count) < DEPTH, computed combinationally from registered state. issue_fire while issue_ok=0 is a protocol violation; the counter still increments.
- Overflow: in_valid while count==DEPTH and no pop this cycle drops the entry and sets overflow_err=1, which stays set until reset.
- Reset mid-operation: all entries and the in-flight count are discarded, with no further cdb_req. Results arriving from the divider after reset are pushed normally; the divider resets concurrently, so none arrive.
- All registers update on posedge clk except for the asynchronous reset.

Optional Feature:
Macro DIV_CDB_BYPASS_EN.
- Defined: when count==0 and in_valid=1, cdb_req is asserted combinationally in the same cycle, with cdb_result/tag/pc driven directly from in_result/in_tag/in_pc. If cdb_grant=1 that cycle, the entry is not written and count stays 0 (zero-cycle latency). If not granted, it is pushed normally. Credit accounting is unchanged: the in-flight counter decrements on in_valid either way.
- Undefined: no combinational path from in_* to cdb_*; minimum latency is 1 cycle.

Test Plan:
- Reset then single op: issue_fire for 1 cycle, in_valid 32 cycles later with result=0x0000_0007, tag=5, pc=0x100. Required: cdb_req=1 next cycle with those values; grant pops it; count returns to 0.
- Credit limit, DEPTH=8, cdb_grant held 0: issue_fire 8 consecutive cycles. Required: issue_ok=0 after the 8th. After 8 in_valid pushes, count=8 and issue_ok stays 0. One grant gives count=7 and issue_ok=1.
- Full with simultaneous push+pop: count=8, in_valid=1 and cdb_grant=1 in the same cycle. Required: count stays 8, overflow_err=0, and the FIFO order after wrap-around is preserved.
- Overflow: force in_valid with count=8 and cdb_grant=0. Required: overflow_err=1 (sticky), count=8, head data unchanged.
- Simultaneous issue_fire and in_valid with inflight=3. Required: inflight stays 3. Asynchronous reset asserted mid-stream with count=4: outputs go to 0 immediately, and issue_ok=1 after reset.
- Under DIV_CDB_BYPASS_EN: buffer empty, in_valid with result=0xDEAD_BEEF and cdb_grant=1 in the same cycle. Required: cdb_req=1 and cdb_result=0xDEAD_BEEF that cycle, and count=0 the next cycle.

Source files
------------

// File: rtl/div_cdb_buffer.sv
// Writeback buffer between the pipelined divider and the CDB arbiter, with issue credits.
// Optional same-cycle bypass of an empty buffer when DIV_CDB_BYPASS_EN is defined.
module div_cdb_buffer #(
  parameter int DEPTH        = 8,
  parameter int DATA_W       = 32,
  parameter int TAG_W        = 7,
  parameter int PC_W         = 32,
  parameter int MAX_INFLIGHT = 33
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     issue_fire,
  output logic                     issue_ok,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_result,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic [PC_W-1:0]          in_pc,
  output logic                     cdb_req,
  input  logic                     cdb_grant,
  output logic [DATA_W-1:0]        cdb_result,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [PC_W-1:0]          cdb_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int INF_W = $clog2(MAX_INFLIGHT + 1);
  localparam int SUM_W = ((INF_W > CNT_W) ? INF_W : CNT_W) + 1;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [TAG_W-1:0]  tag;
    logic [PC_W-1:0]   pc;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [INF_W-1:0]   inflight_q, inflight_d;
  logic               overflow_q, overflow_d;

  logic               empty;
  logic               full;
  logic               pop_buf;
  logic               bypass_vld;
  logic               bypass_take;
  logic               push;
  entry_t             in_entry;
  logic [SUM_W-1:0]   credit_sum;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign pop_buf  = cdb_grant & ~empty;
  assign in_entry = '{result: in_result, tag: in_tag, pc: in_pc};

`ifdef DIV_CDB_BYPASS_EN
  assign bypass_vld = in_valid & empty;
`else
  assign bypass_vld = 1'b0;
`endif
  assign bypass_take = bypass_vld & cdb_grant;

  // A pop in the same cycle frees the slot, so a push into a full buffer is legal then.
  assign push = in_valid & ~bypass_take & (~full | pop_buf);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_buf) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop_buf) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop_buf) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Spurious completions never drive the in-flight count below zero.
  always_comb begin
    inflight_d = inflight_q;
    if (issue_fire && !in_valid) begin
      if (inflight_q != '1) begin
        inflight_d = inflight_q + INF_W'(1);
      end
    end else if (in_valid && !issue_fire) begin
      if (inflight_q != '0) begin
        inflight_d = inflight_q - INF_W'(1);
      end
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    if (in_valid && full && !pop_buf) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    cdb_req    = 1'b0;
    cdb_result = '0;
    cdb_tag    = '0;
    cdb_pc     = '0;
    if (!empty) begin
      cdb_req    = 1'b1;
      cdb_result = mem_q[rd_ptr_q].result;
      cdb_tag    = mem_q[rd_ptr_q].tag;
      cdb_pc     = mem_q[rd_ptr_q].pc;
    end
`ifdef DIV_CDB_BYPASS_EN
    else if (bypass_vld) begin
      cdb_req    = 1'b1;
      cdb_result = in_result;
      cdb_tag    = in_tag;
      cdb_pc     = in_pc;
    end
`endif
  end

  // Credits cover both queued entries and operations still inside the divider.
  assign credit_sum   = SUM_W'(inflight_q) + SUM_W'(count_q);
  assign issue_ok     = (credit_sum < SUM_W'(DEPTH));
  assign count        = count_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_div_cdb_buffer.sv
// Directed, table-driven bench for div_cdb_buffer (default DEPTH=8).
module tb_div_cdb_buffer;

  logic        clk;
  logic        reset;
  logic        issue_fire;
  logic        issue_ok;
  logic        in_valid;
  logic [31:0] in_result;
  logic [6:0]  in_tag;
  logic [31:0] in_pc;
  logic        cdb_req;
  logic        cdb_grant;
  logic [31:0] cdb_result;
  logic [6:0]  cdb_tag;
  logic [31:0] cdb_pc;
  logic [3:0]  count;
  logic        overflow_err;

  int checks = 0;
  int failures = 0;

  div_cdb_buffer dut (
    .clk(clk), .reset(reset),
    .issue_fire(issue_fire), .issue_ok(issue_ok),
    .in_valid(in_valid), .in_result(in_result), .in_tag(in_tag), .in_pc(in_pc),
    .cdb_req(cdb_req), .cdb_grant(cdb_grant),
    .cdb_result(cdb_result), .cdb_tag(cdb_tag), .cdb_pc(cdb_pc),
    .count(count), .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fire;
    logic        valid;
    logic        grant;
    logic [31:0] res;
    logic [6:0]  tag;
    logic [31:0] pc;
    int          rep;
    logic        e_req;
    logic [31:0] e_res;
    logic [6:0]  e_tag;
    logic [31:0] e_pc;
    logic [3:0]  e_cnt;
    logic        e_ok;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic fire, logic valid, logic grant,
                              logic [31:0] res, logic [6:0] tag, logic [31:0] pc, int rep,
                              logic e_req, logic [31:0] e_res, logic [6:0] e_tag,
                              logic [31:0] e_pc, logic [3:0] e_cnt, logic e_ok, logic e_ovf);
    vec_t v;
    v.fire = fire; v.valid = valid; v.grant = grant;
    v.res = res; v.tag = tag; v.pc = pc; v.rep = rep;
    v.e_req = e_req; v.e_res = e_res; v.e_tag = e_tag; v.e_pc = e_pc;
    v.e_cnt = e_cnt; v.e_ok = e_ok; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic check(string name, logic e_req, logic [31:0] e_res, logic [6:0] e_tag,
                       logic [31:0] e_pc, logic [3:0] e_cnt, logic e_ok, logic e_ovf);
    checks += 7;
    if (cdb_req !== e_req) begin
      failures++; $display("FAIL %s cdb_req got=%b exp=%b", name, cdb_req, e_req);
    end
    if (cdb_result !== e_res) begin
      failures++; $display("FAIL %s cdb_result got=%h exp=%h", name, cdb_result, e_res);
    end
    if (cdb_tag !== e_tag) begin
      failures++; $display("FAIL %s cdb_tag got=%h exp=%h", name, cdb_tag, e_tag);
    end
    if (cdb_pc !== e_pc) begin
      failures++; $display("FAIL %s cdb_pc got=%h exp=%h", name, cdb_pc, e_pc);
    end
    if (count !== e_cnt) begin
      failures++; $display("FAIL %s count got=%0d exp=%0d", name, count, e_cnt);
    end
    if (issue_ok !== e_ok) begin
      failures++; $display("FAIL %s issue_ok got=%b exp=%b", name, issue_ok, e_ok);
    end
    if (overflow_err !== e_ovf) begin
      failures++; $display("FAIL %s overflow_err got=%b exp=%b", name, overflow_err, e_ovf);
    end
  endtask

  task automatic clear_inputs();
    issue_fire = 1'b0; in_valid = 1'b0; cdb_grant = 1'b0;
    in_result = '0; in_tag = '0; in_pc = '0;
  endtask

  // One clock with the given inputs; inputs are dropped 1ns after the edge.
  task automatic step(logic fire, logic valid, logic grant,
                      logic [31:0] res, logic [6:0] tag, logic [31:0] pc);
    @(negedge clk);
    issue_fire = fire; in_valid = valid; cdb_grant = grant;
    in_result = res; in_tag = tag; in_pc = pc;
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    logic [31:0] hr;
    clear_inputs();
    reset = 1'b1;

    // single op: issue, 32-cycle latency, push, pop
    vecs.push_back(mk(1,0,0, 0,0,0, 1,      0,0,0,0, 0,1,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 31,     0,0,0,0, 0,1,0));
    vecs.push_back(mk(0,1,0, 32'h7,5,32'h100, 1, 1,32'h7,5,32'h100, 1,1,0));
    vecs.push_back(mk(0,0,1, 0,0,0, 1,      0,0,0,0, 0,1,0));
    // credit limit: 8 issues exhaust credit
    vecs.push_back(mk(1,0,0, 0,0,0, 7,      0,0,0,0, 0,1,0));
    vecs.push_back(mk(1,0,0, 0,0,0, 1,      0,0,0,0, 0,0,0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0,1,0, 32'h10+i, 7'(i), 32'h200+4*i, 1,
                        1,32'h10,0,32'h200, 4'(i+1),0,0));
    vecs.push_back(mk(0,0,1, 0,0,0, 1,      1,32'h11,1,32'h204, 7,1,0));
    // refill to full, then push+pop while full
    vecs.push_back(mk(0,1,0, 32'h18,8,32'h220, 1, 1,32'h11,1,32'h204, 8,0,0));
    vecs.push_back(mk(0,1,1, 32'h19,9,32'h224, 1, 1,32'h12,2,32'h208, 8,0,0));
    // overflow: entry dropped, head unchanged
    vecs.push_back(mk(0,1,0, 32'h99,7'h7f,32'hdead, 1, 1,32'h12,2,32'h208, 8,0,1));
    // drain: wrap-around order preserved, 0x99 never appears
    for (int k = 1; k <= 8; k++) begin
      if (k < 8)
        vecs.push_back(mk(0,0,1, 0,0,0, 1, 1,32'h12+k,7'(2+k),32'h208+4*k, 4'(8-k),1,1));
      else
        vecs.push_back(mk(0,0,1, 0,0,0, 1, 0,0,0,0, 0,1,1));
    end

    do_reset();
    check("reset", 0,0,0,0, 0,1,0);

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].rep; r++)
        step(vecs[i].fire, vecs[i].valid, vecs[i].grant, vecs[i].res, vecs[i].tag, vecs[i].pc);
      check($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_res, vecs[i].e_tag, vecs[i].e_pc,
            vecs[i].e_cnt, vecs[i].e_ok, vecs[i].e_ovf);
    end

    // simultaneous issue and completion with inflight=3
    do_reset();
    check("reset2", 0,0,0,0, 0,1,0);
    repeat (3) step(1,0,0, 0,0,0);
    step(1,1,0, 32'h55,1,32'h300);
    check("fire_and_valid", 1,32'h55,1,32'h300, 1,1,0);
    repeat (3) step(1,0,0, 0,0,0);
    check("inflight6", 1,32'h55,1,32'h300, 1,1,0);
    step(1,0,0, 0,0,0);
    check("inflight7", 1,32'h55,1,32'h300, 1,0,0);
    for (int i = 0; i < 3; i++) step(0,1,0, 32'h56+i, 7'(2+i), 32'h304+4*i);
    check("count4", 1,32'h55,1,32'h300, 4,0,0);

    // asynchronous reset mid-cycle
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset", 0,0,0,0, 0,1,0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("after_reset", 0,0,0,0, 0,1,0);

    // empty-buffer completion with same-cycle grant
    @(negedge clk);
    in_valid = 1'b1; in_result = 32'hDEADBEEF; in_tag = 7'h22; in_pc = 32'h400;
    cdb_grant = 1'b1;
    #1;
`ifdef DIV_CDB_BYPASS_EN
    check("bypass_same", 1,32'hDEADBEEF,7'h22,32'h400, 0,1,0);
`else
    check("no_bypass_same", 0,0,0,0, 0,1,0);
`endif
    @(posedge clk);
    #1;
    clear_inputs();
`ifdef DIV_CDB_BYPASS_EN
    check("bypass_next", 0,0,0,0, 0,1,0);
`else
    check("no_bypass_next", 1,32'hDEADBEEF,7'h22,32'h400, 1,1,0);
`endif
    hr = cdb_result;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
